// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and instruction-RAM loader: packs decoded field bundles into
// 32-bit words and writes them to consecutive word addresses starting at a programmable base.
module instr_encoder_loader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        op,
    input  logic [2:0]        fn3,
    input  logic [6:0]        fn7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic [2:0]        imm_type,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam int CW = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] T_R = 3'd0;
    localparam logic [2:0] T_I = 3'd1;
    localparam logic [2:0] T_S = 3'd2;
    localparam logic [2:0] T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4;
    localparam logic [2:0] T_J = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_in_ready;
    logic              r_full;
    logic              r_err;
    logic              r_closing;

    logic              w_shift;
    logic              w_fits12;
    logic              w_legal;
    logic [31:0]       w_insn;
    logic              w_accept;
    logic              w_wr_next;
    logic [ADDR_W:0]   w_count_next;
    logic [ADDR_W-1:0] w_ptr_next;
    logic              w_room;

    assign w_shift  = (imm_type == T_I) && (op == 7'b0010011) &&
                      ((fn3 == 3'b001) || (fn3 == 3'b101));
    assign w_fits12 = (imm[31:11] == {21{imm[31]}});

    always_comb begin
        w_insn  = 32'h0;
        w_legal = 1'b0;
        case (imm_type)
            T_R: begin
                w_insn  = {fn7, rs2, rs1, fn3, rd, op};
                w_legal = 1'b1;
            end
            T_I: begin
                if (w_shift) begin
                    w_insn  = {fn7, imm[4:0], rs1, fn3, rd, op};
                    w_legal = (imm[31:5] == 27'h0);
                end else begin
                    w_insn  = {imm[11:0], rs1, fn3, rd, op};
                    w_legal = w_fits12;
                end
            end
            T_S: begin
                w_insn  = {imm[11:5], rs2, rs1, fn3, imm[4:0], op};
                w_legal = w_fits12;
            end
            T_B: begin
                w_insn  = {imm[12], imm[10:5], rs2, rs1, fn3, imm[4:1], imm[11], op};
                w_legal = (imm[31:12] == {20{imm[31]}}) && !imm[0];
            end
            T_U: begin
                w_insn  = {imm[31:12], rd, op};
                w_legal = (imm[11:0] == 12'h0);
            end
            T_J: begin
                w_insn  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                w_legal = (imm[31:20] == {12{imm[31]}}) && !imm[0];
            end
            default: begin
                w_insn  = 32'h0;
                w_legal = 1'b0;
            end
        endcase
    end

    // The pending write always retires at the next edge, so pointer and count
    // advance exactly when imem_we has been high for a cycle.
    assign w_accept     = in_valid && r_in_ready;
    assign w_wr_next    = w_accept && w_legal;
    assign w_count_next = r_count + CW'(r_we);
    assign w_ptr_next   = r_ptr + ADDR_W'(r_we);
    assign w_room       = (w_count_next + CW'(w_wr_next)) < DEPTH_C;

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_in_ready <= 1'b0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_closing  <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_ptr   <= w_ptr_next;
            r_count <= w_count_next;
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b0;
                    r_full     <= 1'b0;
                    r_closing  <= 1'b0;
                    if (start) begin
                        r_state    <= S_RUN;
                        r_ptr      <= base_addr;
                        r_count    <= '0;
                        r_err      <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_we    <= 1'b1;
                            r_addr  <= w_ptr_next;
                            r_wdata <= w_insn;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    if (r_closing) begin
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b0;
                        r_closing  <= 1'b0;
                    end else if (finish) begin
                        // A word accepted together with finish is still written first.
                        r_in_ready <= 1'b0;
                        if (w_wr_next) begin
                            r_closing <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_count_next == DEPTH_C) begin
                        r_state    <= S_FULL;
                        r_full     <= 1'b1;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_in_ready <= w_room;
                    end
                end
                S_FULL: begin
                    r_in_ready <= 1'b0;
                    if (finish) begin
                        r_state <= S_IDLE;
                        r_full  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign busy       = (r_state != S_IDLE);
    assign full       = r_full;
    assign err        = r_err;
    assign dbg_state  = r_state;

endmodule
